// File: rtl/rv32i_pipeline_top.sv
// rv32i_pipeline_top: five-stage RV32I-subset core with host-loadable instruction memory,
// MEM/WB forwarding, load-use stall and EX-resolved branches/JAL.
module rv32i_pipeline_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        resetpc,
  input  logic        we0,
  input  logic [8:0]  wr_addr0,
  input  logic [31:0] wr_din0
);
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_XOR = 3'd4, ALU_SLT = 3'd5;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
    logic       jal;
    logic       use_imm;
    logic [2:0] alu;
  } ctrl_t;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [8:0]  pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;
  logic [31:0]        imem [128];
  logic [31:0][31:0]  rf;
  logic [63:0][31:0]  dmem;
  logic [8:0]         pc, fd_pc;
  logic [31:0]        fd_instr;
  id_ex_t             de;
  logic               em_we, em_mem_read, em_mem_write;
  logic [4:0]         em_rd;
  logic [31:0]        em_result, em_store;
  logic               mw_we;
  logic [4:0]         mw_rd;
  logic [31:0]        mw_data;
  logic [4:0]         rs1, rs2, rd;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [31:0]        rv1, rv2, imm;
  ctrl_t              ctrl;
  logic               use_rs1, use_rs2, load_use;
  logic [31:0]        dmem_rdata, em_fwd, fa, fb, opb, alu_y, ex_result;
  logic               taken;
  logic [8:0]         target;
  logic               unused_addr;

  assign unused_addr = ^wr_addr0[1:0];
  assign {f7, rs2, rs1, f3, rd} = fd_instr[31:7];

  function automatic logic [2:0] alu_of(input logic [2:0] f);
    return f == 3'b111 ? ALU_AND : f == 3'b110 ? ALU_OR : f == 3'b100 ? ALU_XOR : f == 3'b010 ? ALU_SLT : ALU_ADD;
  endfunction

  // Unsupported encodings fall through with all control bits clear, i.e. a NOP.
  always_comb begin
    ctrl = '0;
    imm = {{20{fd_instr[31]}}, fd_instr[31:20]};
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (fd_instr[6:0])
      7'b0110011: if ((f7 == 7'h00 && f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111}) || (f7 == 7'h20 && f3 == 3'b000)) begin
        ctrl.reg_write = 1'b1;
        ctrl.alu = f7[5] ? ALU_SUB : alu_of(f3);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011: if (f3 inside {3'b000, 3'b010, 3'b110, 3'b111}) begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm = 1'b1;
        ctrl.alu = alu_of(f3);
        use_rs1 = 1'b1;
      end
      7'b0000011: if (f3 == 3'b010) begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.use_imm = 1'b1;
        use_rs1 = 1'b1;
      end
      7'b0100011: if (f3 == 3'b010) begin
        ctrl.mem_write = 1'b1;
        ctrl.use_imm = 1'b1;
        imm = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1100011: if (f3[2:1] == 2'b00) begin
        ctrl.branch = 1'b1;
        ctrl.bne = f3[0];
        imm = {{19{fd_instr[31]}}, fd_instr[31], fd_instr[7], fd_instr[30:25], fd_instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b1101111: begin
        ctrl.reg_write = 1'b1;
        ctrl.jal = 1'b1;
        imm = {{11{fd_instr[31]}}, fd_instr[31], fd_instr[19:12], fd_instr[20], fd_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Write-through so ID sees the value WB commits on the coming edge.
  assign rv1 = rs1 == 5'd0 ? '0 : (mw_we && mw_rd == rs1) ? mw_data : rf[rs1];
  assign rv2 = rs2 == 5'd0 ? '0 : (mw_we && mw_rd == rs2) ? mw_data : rf[rs2];
  assign load_use = de.ctrl.mem_read && de.rd != 5'd0 && ((use_rs1 && rs1 == de.rd) || (use_rs2 && rs2 == de.rd));

  assign dmem_rdata = dmem[em_result[7:2]];
  assign em_fwd = em_mem_read ? dmem_rdata : em_result;
  assign fa = (de.rs1 != 5'd0 && em_we && em_rd == de.rs1) ? em_fwd : (de.rs1 != 5'd0 && mw_we && mw_rd == de.rs1) ? mw_data : de.a;
  assign fb = (de.rs2 != 5'd0 && em_we && em_rd == de.rs2) ? em_fwd : (de.rs2 != 5'd0 && mw_we && mw_rd == de.rs2) ? mw_data : de.b;
  assign opb = de.ctrl.use_imm ? de.imm : fb;
  assign alu_y = de.ctrl.alu == ALU_SUB ? fa - opb :
                 de.ctrl.alu == ALU_AND ? fa & opb :
                 de.ctrl.alu == ALU_OR  ? fa | opb :
                 de.ctrl.alu == ALU_XOR ? fa ^ opb :
                 de.ctrl.alu == ALU_SLT ? {31'd0, $signed(fa) < $signed(opb)} : fa + opb;
  assign ex_result = de.ctrl.jal ? {23'd0, de.pc + 9'd4} : alu_y;
  assign taken = de.ctrl.jal || (de.ctrl.branch && ((fa == fb) != de.ctrl.bne));
  assign target = de.pc + de.imm[8:0];

  always_ff @(posedge clk)
    if (we0) imem[wr_addr0[8:2]] <= wr_din0;

  // A taken branch outranks a load-use stall: the stalled instruction is on the wrong path.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= '0;
      fd_pc <= '0;
      fd_instr <= '0;
      de <= '0;
      {em_we, em_mem_read, em_mem_write, em_rd, em_result, em_store} <= '0;
      {mw_we, mw_rd, mw_data} <= '0;
    end else begin
      pc <= !resetpc ? 9'd0 : taken ? target : load_use ? pc : pc + 9'd4;
      fd_pc <= taken ? 9'd0 : load_use ? fd_pc : resetpc ? pc : 9'd0;
      fd_instr <= taken ? '0 : load_use ? fd_instr : resetpc ? imem[pc[8:2]] : '0;
      de <= (taken || load_use) ? '0 : {ctrl, fd_pc, rs1, rs2, rd, rv1, rv2, imm};
      {em_we, em_mem_read, em_mem_write, em_rd, em_result, em_store} <= {de.ctrl.reg_write, de.ctrl.mem_read, de.ctrl.mem_write, de.rd, ex_result, fb};
      {mw_we, mw_rd, mw_data} <= {em_we, em_rd, em_fwd};
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) rf <= '0;
    else if (mw_we && mw_rd != 5'd0) rf[mw_rd] <= mw_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) dmem <= '0;
    else if (em_mem_write) dmem[em_result[7:2]] <= em_store;
endmodule

// File: tb/tb_rv32i_pipeline_top.sv
// tb_rv32i_pipeline_top: directed programs; a scoreboard holds each expected register
// writeback (rd, value, commit edge after release) and a monitor checks WB against it.
module tb_rv32i_pipeline_top;
  logic        clk = 1'b0, reset = 1'b1, resetpc = 1'b0, we0 = 1'b0;
  logic [8:0]  wr_addr0 = '0;
  logic [31:0] wr_din0 = '0;
  int          checks = 0, errors = 0, cyc = 0, t0 = 0, nz = 0;
  typedef struct { logic [4:0] rd; logic [31:0] data; int at; } wb_t;
  wb_t         sb [$];
  wb_t         e;
  logic [31:0] prog [32];
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  OPI = 7'b0010011;

  rv32i_pipeline_top dut (.clk(clk), .reset(reset), .resetpc(resetpc), .we0(we0), .wr_addr0(wr_addr0), .wr_din0(wr_din0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] itype(input logic [2:0] f3, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return itype(3'b000, OPI, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input int at);
    sb.push_back('{rd, data, at});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic start();
    @(negedge clk);
    reset = 1'b1;
    resetpc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we0 = 1'b1;
      wr_addr0 = 9'(i * 4);
      wr_din0 = prog[i];
      @(negedge clk);
    end
    we0 = 1'b0;
  endtask

  task automatic go(input int n);
    resetpc = 1'b1;
    t0 = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic finish_prog(input string name);
    @(negedge clk);
    resetpc = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({name, "_drain"}, 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic expect_p7();
    expect_wb(1, 5, 4);
    expect_wb(2, 7, 5);
    expect_wb(3, 12, 6);
    expect_wb(8, 32'hffff_ffff, 8);
    expect_wb(9, 1, 9);
    expect_wb(10, 2, 10);
    expect_wb(11, 7, 11);
    expect_wb(12, 5, 12);
    expect_wb(13, 1, 13);
    expect_wb(14, 4, 14);
    expect_wb(15, 15, 15);
  endtask

  always @(negedge clk)
    if (dut.mw_we && dut.mw_rd != 5'd0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected actual x%0d=%0h at edge %0d required no write", dut.mw_rd, dut.mw_data, cyc - t0);
      end else begin
        e = sb.pop_front();
        if (e.rd !== dut.mw_rd || e.data !== dut.mw_data || e.at != cyc - t0) begin
          errors++;
          $display("FAIL wb actual x%0d=%0h at edge %0d required x%0d=%0h at edge %0d", dut.mw_rd, dut.mw_data, cyc - t0, e.rd, e.data, e.at);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    prog = '{default: NOP};
    prog[0] = addi(1, 0, 5);
    prog[1] = addi(2, 0, 7);
    prog[2] = rtype(0, 0, 3, 1, 2);
    prog[3] = addi(0, 0, 9);
    prog[4] = addi(4, 0, 1);
    start();
    check("reset_pc_init", 32'(dut.pc), 0);
    expect_wb(1, 5, 4);
    expect_wb(2, 7, 5);
    expect_wb(3, 12, 6);
    expect_wb(4, 1, 8);
    go(24);
    check("x0_zero", dut.rf[0], 0);
    finish_prog("load_run");

    prog = '{default: NOP};
    prog[0] = addi(1, 0, 3);
    prog[1] = rtype(0, 0, 2, 1, 1);
    prog[2] = rtype(7'h20, 0, 3, 2, 1);
    start();
    expect_wb(1, 3, 4);
    expect_wb(2, 6, 5);
    expect_wb(3, 3, 6);
    go(24);
    finish_prog("forward");

    prog = '{default: NOP};
    prog[0] = addi(1, 0, 42);
    prog[1] = sw(1, 0, 8);
    prog[2] = itype(3'b010, 7'b0000011, 4, 0, 8);
    prog[3] = rtype(0, 0, 5, 4, 4);
    start();
    expect_wb(1, 42, 4);
    expect_wb(4, 42, 6);
    expect_wb(5, 84, 8);
    go(24);
    check("dmem2", dut.dmem[2], 42);
    finish_prog("load_use");

    prog = '{default: NOP};
    prog[0] = br(3'b000, 0, 0, 8);
    prog[1] = addi(6, 0, 1);
    prog[2] = addi(7, 0, 9);
    start();
    expect_wb(7, 9, 7);
    go(24);
    check("beq_x6_flushed", dut.rf[6], 0);
    finish_prog("beq");

    prog[0] = br(3'b001, 0, 0, 8);
    start();
    expect_wb(6, 1, 5);
    expect_wb(7, 9, 6);
    go(24);
    finish_prog("bne");

    prog = '{default: NOP};
    prog[4] = jal(1, 12);
    prog[5] = addi(2, 0, 1);
    prog[6] = addi(3, 0, 2);
    prog[7] = addi(4, 0, 7);
    start();
    expect_wb(1, 20, 8);
    expect_wb(4, 7, 11);
    go(24);
    check("jal_x2_flushed", dut.rf[2], 0);
    check("jal_x3_flushed", dut.rf[3], 0);
    finish_prog("jal");

    prog = '{default: NOP};
    prog[0] = addi(1, 0, 5);
    prog[1] = addi(2, 0, 7);
    prog[2] = rtype(0, 0, 3, 1, 2);
    prog[3] = sw(3, 0, 4);
    prog[4] = addi(8, 0, 12'hfff);
    prog[5] = rtype(0, 3'b010, 9, 8, 0);
    prog[6] = rtype(0, 3'b100, 10, 1, 2);
    prog[7] = rtype(0, 3'b110, 11, 1, 2);
    prog[8] = rtype(0, 3'b111, 12, 1, 2);
    prog[9] = itype(3'b010, OPI, 13, 1, 6);
    prog[10] = itype(3'b111, OPI, 14, 1, 4);
    prog[11] = itype(3'b110, OPI, 15, 2, 8);
    start();
    expect_p7();
    go(8);
    #1;
    check("pre_reset_x3", dut.rf[3], 12);
    check("pre_reset_dmem1", dut.dmem[1], 12);
    reset = 1'b1;
    resetpc = 1'b0;
    #1;
    sb.delete();
    check("reset_pc", 32'(dut.pc), 0);
    nz = 0;
    for (int i = 0; i < 32; i++) nz += (dut.rf[i] != 0) ? 1 : 0;
    check("reset_rf_nonzero", 32'(nz), 0);
    check("reset_dmem1", dut.dmem[1], 0);
    nz = 0;
    for (int i = 0; i < 32; i++) nz += (dut.imem[i] !== prog[i]) ? 1 : 0;
    check("imem_kept", 32'(nz), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_p7();
    go(24);
    check("rerun_dmem1", dut.dmem[1], 12);
    finish_prog("reset_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_pipeline_top.md
# rv32i_pipeline_top

Five-stage pipelined RV32I-subset processor core with an integrated, externally loadable instruction memory, register file and data memory. A host loads a program through a word write port while the core is held. The host then releases the PC hold, and the core executes from address 0. It is the top-level block of the pipeline lab design and has no architectural outputs. Results are observed through the internal register file, data memory and PC.

## Interface
- No parameters. Instruction memory is 128 × 32 bits; data memory is 64 × 32 bits; register file is 32 × 32 bits.
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- resetpc  input  1  active-low PC hold: 0 holds the PC at 0 and injects bubbles; 1 lets the core run.
- we0  input  1  instruction-memory write enable.
- wr_addr0  input  9  instruction-memory byte address; word index is wr_addr0[8:2], bits [1:0] ignored.
- wr_din0  input  32  instruction word to write.

## Operation
- Program load:
  - On a rising edge with we0=1, imem[wr_addr0[8:2]] ← wr_din0.
  - Writes are accepted regardless of reset or resetpc. Instruction memory is never cleared.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT.
  - I-type: ADDI, ANDI, ORI, SLTI, LW.
  - S-type: SW.
  - B-type: BEQ, BNE.
  - J-type: JAL.
  - Any other opcode or funct combination executes as a NOP, with no register or memory write.
- Pipeline stages:
  - IF: combinational imem read at pc[8:2].
  - ID: register read and immediate generation.
  - EX: ALU, branch compare and target.
  - MEM: data memory access.
  - WB: register write.
- Arithmetic:
  - 32-bit, wrap-around, no overflow detection.
  - SLT/SLTI compare signed.
  - Immediates are sign-extended.
- Registers and memory:
  - x0 reads 0 always; writes to x0 are discarded.
  - Data memory is word-addressed by ALU result [7:2]. Addresses wrap modulo 256 bytes; misalignment is ignored.
  - LW reads combinationally. SW writes on the rising edge in MEM.
- Hazard handling:
  - EX operands are forwarded from MEM first, then WB. Forwarding applies only when the source register is non-zero.
  - The register file writes in the first half-cycle (negedge) or provides a write-through bypass, so ID sees a same-cycle WB result.
  - Load-use: when the instruction in EX is LW and its rd matches rs1 or rs2 of the instruction in ID, IF and ID hold for one cycle and a bubble enters EX.
  - Control: BEQ, BNE and JAL resolve in EX. When taken, the PC loads the target and the IF/ID and ID/EX registers are flushed, costing 2 cycles.
  - JAL writes pc+4 to rd.
- PC behaviour: the PC advances by 4 and wraps at 512 bytes.
- reset=1 (asynchronous):
  - PC ← 0.
  - All pipeline registers ← bubble (all control bits 0).
  - Register file ← 0.
  - Data memory ← 0.
- resetpc=0 (synchronous): PC is held at 0 and a bubble is fed to ID each cycle. Instructions already in flight drain.

## Timing
- With reset=0 and resetpc=1, the instruction at PC=0 is fetched in the first cycle. Its register write is visible 5 edges later; for example, an ADDI fetched at edge 0 writes at edge 4.
- Steady-state throughput is 1 instruction per cycle.
- Stall and flush costs:
  - Load-use adds 1 cycle.
  - A taken branch or JAL adds 2 cycles.
  - A not-taken branch adds 0 cycles.
- Simultaneous stall and taken branch: the flush takes priority.
- An imem write to the address being fetched in the same cycle: the fetch returns the old word and the new word is seen from the next cycle.
- reset asserted mid-run: the whole core returns to the reset state immediately, and the instruction memory is preserved.

## Test plan
- Load and run:
  - Stimulus: load 7 words via we0 at addresses 0,4,…,24 with resetpc=0, then set resetpc=1.
  - Program: addi x1,x0,5 / addi x2,x0,7 / add x3,x1,x2.
  - Expected: x3=12 after ≤8 cycles; writes to x0 leave it 0.
- Forwarding:
  - Program: addi x1,x0,3 / add x2,x1,x1 / sub x3,x2,x1.
  - Expected: x2=6 and x3=3, with no stall cycles (retire count equals instruction count).
- Load-use:
  - Program: addi x1,x0,42 / sw x1,8(x0) / lw x4,8(x0) / add x5,x4,x4.
  - Expected: dmem[2]=42 and x5=84, with exactly 1 stall.
- Branch:
  - Program: beq x0,x0,+8 / addi x6,x0,1 / addi x7,x0,9.
  - Expected: x6=0 (flushed) and x7=9.
  - Same program with bne x0,x0,+8: expected x6=1.
- JAL:
  - Program: jal x1,+12 at PC=16.
  - Expected: x1=20, next retired instruction at PC=28, and the two following instructions flushed.
- Reset:
  - Stimulus: assert reset mid-program.
  - Expected: PC=0 and all registers 0 immediately. The instruction memory is unchanged, and the program reruns identically after release.
